// File: rtl/tiny_rv_csr_pkg.sv
// tiny_rv_csr_pkg: shared CSR addresses, funct3 encodings, FSM states and mstatus fields
package tiny_rv_csr_pkg;
    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MISA      = 12'h301;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_CYCLE     = 12'hC00;
    localparam logic [11:0] CSR_INSTRET   = 12'hC02;
    localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
    localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    localparam logic [2:0] F3_RW  = 3'd1;
    localparam logic [2:0] F3_RS  = 3'd2;
    localparam logic [2:0] F3_RC  = 3'd3;
    localparam logic [2:0] F3_RWI = 3'd5;
    localparam logic [2:0] F3_RSI = 3'd6;
    localparam logic [2:0] F3_RCI = 3'd7;

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;
endpackage

// File: rtl/tiny_rv_csr_counter64.sv
// tiny_rv_csr_counter64: 64-bit free-running counter with per-half CSR write override
// ports: clk, rst (async high), inc (count enable), wr_lo/wr_hi (load a half from wdata), value
module tiny_rv_csr_counter64 (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [31:0] wdata,
    output logic [63:0] value
);
    // a write suppresses the increment for the whole counter; the unwritten half holds
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            value <= '0;
        else if (wr_lo || wr_hi)
            value <= {wr_hi ? wdata : value[63:32], wr_lo ? wdata : value[31:0]};
        else if (inc)
            value <= value + 64'd1;
    end
endmodule

// File: rtl/tiny_rv_csr_ctrl.sv
// tiny_rv_csr_ctrl: machine-mode CSR file with read/modify/commit sequencer and 64-bit counters
// ports: i_clk, i_rst (async high); request i_req_valid/o_req_ready with i_funct3, i_csr, i_rs1, i_rs1_idx;
//        response o_rsp_valid/i_rsp_ready with o_rsp_data, o_rsp_illegal; i_retire; o_mtvec, o_mepc, o_mie
module tiny_rv_csr_ctrl
    import tiny_rv_csr_pkg::*;
#(
    parameter logic [31:0] HART_ID     = 32'd0,
    parameter logic [31:0] MISA_VALUE  = 32'h4000_0100,
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [2:0]  i_funct3,
    input  logic [11:0] i_csr,
    input  logic [31:0] i_rs1,
    input  logic [4:0]  i_rs1_idx,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [31:0] o_rsp_data,
    output logic        o_rsp_illegal,
    input  logic        i_retire,
    output logic [31:0] o_mtvec,
    output logic [31:0] o_mepc,
    output logic        o_mie
);
    state_t state, state_d;
    logic [2:0] f3_q;
    logic [11:0] csr_q;
    logic [31:0] op_q;
    logic nz_q;
    logic mie, mpie;
    logic [31:0] mtvec, mscratch, mepc, mcause;
    logic [63:0] mcycle, minstret;
    logic [31:0] rdata, wdata;
    logic impl, we, illegal, commit;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            state <= IDLE;
        else
            state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:  state_d = i_req_valid ? READ : IDLE;
            READ:  state_d = WRITE;
            WRITE: state_d = RESP;
            RESP:  state_d = i_rsp_ready ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end

    // o_rsp_data doubles as the captured old value: when it is zeroed for an
    // illegal access the commit is blocked anyway
    always_comb begin
        impl = 1'b1;
        rdata = '0;
        case (csr_q)
            CSR_MSTATUS: begin
                rdata[MSTATUS_MIE] = mie;
                rdata[MSTATUS_MPIE] = mpie;
            end
            CSR_MISA:                  rdata = MISA_VALUE;
            CSR_MTVEC:                 rdata = mtvec;
            CSR_MSCRATCH:              rdata = mscratch;
            CSR_MEPC:                  rdata = mepc;
            CSR_MCAUSE:                rdata = mcause;
            CSR_MCYCLE, CSR_CYCLE:     rdata = mcycle[31:0];
            CSR_MCYCLEH, CSR_CYCLEH:   rdata = mcycle[63:32];
            CSR_MINSTRET, CSR_INSTRET: rdata = minstret[31:0];
            CSR_MINSTRETH, CSR_INSTRETH: rdata = minstret[63:32];
            CSR_MHARTID:               rdata = HART_ID;
            default:                   impl = 1'b0;
        endcase
        we = (f3_q[1:0] == 2'b01) || nz_q;
        illegal = (f3_q[1:0] == 2'b00) || !impl || (we && csr_q[11:10] == 2'b11);
        wdata = f3_q[1:0] == 2'b01 ? op_q : f3_q[1:0] == 2'b10 ? o_rsp_data | op_q : o_rsp_data & ~op_q;
        commit = state == WRITE && we && !o_rsp_illegal;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            f3_q <= '0;
            csr_q <= '0;
            op_q <= '0;
            nz_q <= 1'b0;
            o_rsp_data <= '0;
            o_rsp_illegal <= 1'b0;
            mie <= 1'b0;
            mpie <= 1'b0;
            mtvec <= MTVEC_RESET;
            mscratch <= '0;
            mepc <= '0;
            mcause <= '0;
        end else begin
            if (state == IDLE && i_req_valid) begin
                f3_q <= i_funct3;
                csr_q <= i_csr;
                op_q <= i_funct3[2] ? {27'd0, i_rs1_idx} : i_rs1;
                nz_q <= |i_rs1_idx;
            end
            if (state == READ) begin
                o_rsp_data <= illegal ? '0 : rdata;
                o_rsp_illegal <= illegal;
            end
            if (commit) begin
                case (csr_q)
                    CSR_MSTATUS: begin
                        mie <= wdata[MSTATUS_MIE];
                        mpie <= wdata[MSTATUS_MPIE];
                    end
                    CSR_MTVEC:    mtvec <= wdata;
                    CSR_MSCRATCH: mscratch <= wdata;
                    CSR_MEPC:     mepc <= {wdata[31:2], 2'b00};
                    CSR_MCAUSE:   mcause <= wdata;
                    default: ;
                endcase
            end
        end
    end

    tiny_rv_csr_counter64 u_mcycle (
        .clk(i_clk),
        .rst(i_rst),
        .inc(1'b1),
        .wr_lo(commit && csr_q == CSR_MCYCLE),
        .wr_hi(commit && csr_q == CSR_MCYCLEH),
        .wdata(wdata),
        .value(mcycle)
    );

    tiny_rv_csr_counter64 u_minstret (
        .clk(i_clk),
        .rst(i_rst),
        .inc(i_retire),
        .wr_lo(commit && csr_q == CSR_MINSTRET),
        .wr_hi(commit && csr_q == CSR_MINSTRETH),
        .wdata(wdata),
        .value(minstret)
    );

    assign o_req_ready = state == IDLE;
    assign o_rsp_valid = state == RESP;
    assign o_mtvec = mtvec;
    assign o_mepc = mepc;
    assign o_mie = mie;
endmodule
